// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if
//   Start/busy/done handshake bundle between the freeze stage (master) and
//   the binary-to-BCD converter (slave).
//   start : request a conversion (master -> slave)
//   in    : binary value, captured only on the accepting edge
//   busy  : conversion in progress (slave -> master)
//   done  : one-cycle pulse when out is updated
//   out   : packed BCD result, digit 0 (units) in bits [3:0]
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) ();
  logic                  start;
  logic [WIDTH-1:0]      in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   out;

  modport master (output start, output in, input busy, input done, input out);
  modport slave  (input start, input in, output busy, output done, output out);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential double-dabble binary to packed-BCD converter. One shift/add
//   iteration per clock keeps the datapath to DIGITS independent 4-bit
//   adders. A conversion takes width+1 edges from the accepting edge to the
//   edge that publishes the result.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of bin_to_bcd_seq_if (start/in/busy/done/out)
//
//   state  | meaning
//   IDLE   | waiting for start; out holds last result
//   SHIFT  | width adjust-and-shift iterations
//   LATCH  | copy scratch to out, raise done for one cycle
module bin_to_bcd_seq #(
  parameter int width  = 8,
  parameter int DIGITS = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  bin_to_bcd_seq_if.slave    bus
);

  localparam int CNT_W = $clog2(width + 1);
  localparam int BCD_W = 4 * DIGITS;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam longint unsigned MAX_DEC = pow10(DIGITS);
  localparam longint unsigned MAX_BIN = (64'd1 << width) - 64'd1;

  // Every width-bit value must fit in DIGITS decimal digits.
  if (!(MAX_DEC > MAX_BIN)) begin : g_bad_params
    $error("bin_to_bcd_seq: DIGITS too small for width");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [width-1:0]   r_shift;
  logic [BCD_W-1:0]   r_scratch;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_out;
  logic               r_done;
  logic [BCD_W-1:0]   w_adj;
  logic               w_busy;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_W'(1)) w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      S_SHIFT: w_busy = 1'b1;
      S_LATCH: w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Add-3 correction per digit before the shift; digits never carry into
  // each other because a corrected digit is at most 12.
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_out     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.in;
            r_scratch <= '0;
            r_cnt     <= CNT_W'(width);
          end
        end
        S_SHIFT: begin
          r_scratch <= {w_adj[BCD_W-2:0], r_shift[width-1]};
          r_shift   <= r_shift << 1;
          r_cnt     <= r_cnt - CNT_W'(1);
        end
        S_LATCH: begin
          r_out  <= r_scratch;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign bus.out  = r_out;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;
  localparam int W = 8;
  localparam int D = 3;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  bin_to_bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();

  bin_to_bcd_seq #(.width(W), .DIGITS(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a request is accepted when idle; the decimal result
  // appears width+1 edges later, busy covers the whole wait.
  int          m_left;
  int          m_val;
  logic [11:0] m_out;
  bit          m_done;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0;
      m_val  = 0;
      m_out  = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_out  = to_bcd(m_val);
          m_done = 1'b1;
        end
      end else if (bus.start) begin
        m_val  = int'(bus.in);
        m_left = W + 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    checks++;
    if (bus.busy !== (m_left != 0) || bus.done !== m_done || bus.out !== m_out) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t busy=%b/%b done=%b/%b out=%h/%h",
               $time, bus.busy, (m_left != 0), bus.done, m_done, bus.out, m_out);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Accepts a request on the next edge, then waits for done (bounded).
  task automatic convert(input logic [7:0] v, input logic [11:0] exp, input string name);
    int n;
    bit seen;
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.in    = v;
    @(posedge clk); #2;
    bus.start = 1'b0;
    bus.in    = 8'hxx;
    seen = 0;
    n = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) seen = 1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, 32'(n), 32'd9);
    chk({name, "_out"}, 32'(bus.out), 32'(exp));
    chk({name, "_busy_in_done"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.done) cnt++;
    end
  endtask

  initial begin
    int cnt;
    int last;
    int gap_bad;
    int busy_low_bad;
    checks = 0;
    errors = 0;
    bus.start = 1'b0;
    bus.in    = '0;
    reset_n   = 1'b0;

    // Reset and idle hold
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    count_done(20, cnt);
    chk("idle_no_done", 32'(cnt), 32'd0);
    chk("idle_out", 32'(bus.out), 32'h000);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Basic conversions
    convert(8'd255, 12'h255, "c255");
    convert(8'd0,   12'h000, "c0");
    convert(8'd99,  12'h099, "c99");
    convert(8'd100, 12'h100, "c100");

    // Start while busy is ignored
    @(posedge clk); #2;
    bus.start = 1'b1; bus.in = 8'd42;
    @(posedge clk); #2;
    bus.start = 1'b0; bus.in = 8'hxx;
    repeat (2) @(posedge clk);
    #2 bus.start = 1'b1; bus.in = 8'd7;
    @(posedge clk); #2;
    bus.start = 1'b0; bus.in = 8'hxx;
    count_done(20, cnt);
    chk("busy_ignore_done_count", 32'(cnt), 32'd1);
    chk("busy_ignore_out", 32'(bus.out), 32'h042);

    // Reset mid-conversion
    @(posedge clk); #2;
    bus.start = 1'b1; bus.in = 8'd200;
    @(posedge clk); #2;
    bus.start = 1'b0; bus.in = 8'hxx;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out", 32'(bus.out), 32'h000);
    chk("rst_done", 32'(bus.done), 32'd0);
    @(posedge clk); #2 reset_n = 1'b1;
    count_done(12, cnt);
    chk("rst_no_done", 32'(cnt), 32'd0);
    convert(8'd13, 12'h013, "c13");

    // Back-to-back with start held high
    @(posedge clk); #2;
    bus.start = 1'b1; bus.in = 8'd128;
    last = -1;
    gap_bad = 0;
    busy_low_bad = 0;
    cnt = 0;
    for (int i = 0; i < 41; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (last >= 0 && (i - last) != 10) gap_bad++;
        last = i;
        cnt++;
        if (bus.out !== 12'h128) gap_bad++;
      end
      if ((bus.busy == 1'b0) != (bus.done == 1'b1)) busy_low_bad++;
    end
    chk("b2b_done_count", 32'(cnt), 32'd4);
    chk("b2b_gap_or_out", 32'(gap_bad), 32'd0);
    chk("b2b_busy_low_only_done", 32'(busy_low_bad), 32'd0);
    #1 bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("b2b_final_out", 32'(bus.out), 32'h128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
